// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receiver: deserialises device frames, assembles 3-byte packets and tracks a clamped cursor.
// Optional macro MOUSE_ACCEL_EN doubles any axis delta whose magnitude is 16 or more.
module ps2_mouse_tracker #(
    parameter int TIMEOUT_CYC = 65000,
    parameter int XMAX        = 1023,
    parameter int YMAX        = 767,
    parameter int X_INIT      = 512,
    parameter int Y_INIT      = 384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        btn_left,
    output logic        btn_right,
    output logic        pkt_valid,
    output logic        frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [11:0] XMAX_L = 12'(XMAX);
    localparam logic [11:0] YMAX_L = 12'(YMAX);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state;
    logic            clk_s1, clk_s2, clk_d;
    logic            data_s1, data_s2;
    logic            fall;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [1:0]      byte_idx;
    logic [5:0]      hdr;      // {Yovf, Xovf, Ysign, Xsign, R, L} from byte 0
    logic [7:0]      b1;
    logic [TW-1:0]   to_cnt;
    logic signed [13:0] dx, dy, nx, ny;

    function automatic logic signed [13:0] delta(input logic sgn, input logic [7:0] low,
                                                 input logic ovf);
        logic signed [13:0] d;
        d = ovf ? 14'sd0 : $signed({{6{sgn}}, low});
`ifdef MOUSE_ACCEL_EN
        if (d >= 14'sd16 || d <= -14'sd16) d = d <<< 1;
`endif
        return d;
    endfunction

    function automatic logic [11:0] clamp(input logic signed [13:0] v, input logic [11:0] maxv);
        if (v < 14'sd0) return '0;
        else if (v > $signed({2'b00, maxv})) return maxv;
        else return v[11:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_d   <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_d   <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fall = clk_d & ~clk_s2;

    // shreg holds byte 2 at the moment its stop bit is accepted.
    always_comb begin
        dx = delta(hdr[2], b1, hdr[4]);
        dy = delta(hdr[3], shreg, hdr[5]);
        nx = $signed({2'b00, xpos}) + dx;
        ny = $signed({2'b00, ypos}) - dy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            byte_idx  <= '0;
            hdr       <= '0;
            b1        <= '0;
            to_cnt    <= '0;
            xpos      <= 12'(X_INIT);
            ypos      <= 12'(Y_INIT);
            btn_left  <= 1'b0;
            btn_right <= 1'b0;
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_s2;
                        state   <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (data_s2 && (^{shreg, par_bit})) begin
                            case (byte_idx)
                                2'd0: begin
                                    if (shreg[3]) begin
                                        hdr      <= {shreg[7:4], shreg[1:0]};
                                        byte_idx <= 2'd1;
                                    end
                                end
                                2'd1: begin
                                    b1       <= shreg;
                                    byte_idx <= 2'd2;
                                end
                                default: begin
                                    byte_idx  <= 2'd0;
                                    xpos      <= clamp(nx, XMAX_L);
                                    ypos      <= clamp(ny, YMAX_L);
                                    btn_left  <= hdr[0];
                                    btn_right <= hdr[1];
                                    pkt_valid <= 1'b1;
                                end
                            endcase
                        end else begin
                            frame_err <= 1'b1;
                            byte_idx  <= 2'd0;
                        end
                    end
                endcase
            end else if (state != IDLE || byte_idx != 2'd0) begin
                if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    frame_err <= 1'b1;
                    state     <= IDLE;
                    byte_idx  <= 2'd0;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Scoreboard bench for ps2_mouse_tracker: directed packets, expected events queued, monitor pops on strobes.
module tb_ps2_mouse_tracker;
    localparam int TO   = 300;
    localparam int HALF = 8;
    localparam int GAP  = 20;
`ifdef MOUSE_ACCEL_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif
    localparam logic [27:0] ERR_EV = {2'd2, 26'd0};

    logic        clk = 1'b0;
    logic        rst, ps2_clk, ps2_data;
    logic [11:0] xpos, ypos;
    logic        btn_left, btn_right, pkt_valid, frame_err;

    logic [27:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    ps2_mouse_tracker #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .xpos(xpos), .ypos(ypos), .btn_left(btn_left), .btn_right(btn_right),
        .pkt_valid(pkt_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] pkt_ev(input logic l, input logic r, input int x, input int y);
        return {2'd1, l, r, 12'(x), 12'(y)};
    endfunction

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        logic [27:0] got;
        logic [27:0] exp;
        if (!rst && (pkt_valid || frame_err)) begin
            checks++;
            if (pkt_valid && frame_err) begin
                errors++;
                $display("FAIL both_strobes got pkt_valid=1 frame_err=1 required exclusive");
            end
            got = pkt_valid ? {2'd1, btn_left, btn_right, xpos, ypos} : ERR_EV;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got=%h required=none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL event got kind=%0d l=%0d r=%0d x=%0d y=%0d required kind=%0d l=%0d r=%0d x=%0d y=%0d",
                             got[27:26], got[25], got[24], got[23:12], got[11:0],
                             exp[27:26], exp[25], exp[24], exp[23:12], exp[11:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [27:0] exp);
        exp_q.push_back(exp);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    int x_up_na[4] = '{290, 545, 800, 1023};
    int x_up_ac[4] = '{565, 1023, 1023, 1023};

    initial begin
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_x", xpos, 512);
        check("reset_y", ypos, 384);
        check("reset_btn_left", btn_left, 0);
        check("reset_btn_right", btn_right, 0);
        check("reset_pkt_valid", pkt_valid, 0);
        check("reset_frame_err", frame_err, 0);

        repeat (2 * TO) @(negedge clk);
        check("idle_x", xpos, 512);
        check("idle_y", ypos, 384);

        send_pkt(8'h09, 8'h0A, 8'h05, pkt_ev(1, 0, 522, 379));
        send_pkt(8'h38, 8'hF6, 8'h00, pkt_ev(0, 0, 512, ACC ? 767 : 635));
        send_pkt(8'h38, 8'hF6, 8'h00, pkt_ev(0, 0, 502, 767));
        send_pkt(8'h38, 8'hF6, 8'h00, pkt_ev(0, 0, 492, 767));

        // Bad parity on the second byte of a packet.
        exp_q.push_back(ERR_EV);
        send_byte(8'h09, 1'b0);
        send_byte(8'h0A, 1'b1);
        send_pkt(8'h0A, 8'h05, 8'hFB, pkt_ev(0, 1, 497, ACC ? 265 : 516));

        // Stray header without bit3 is dropped silently.
        send_byte(8'h00, 1'b0);
        send_pkt(8'h09, 8'hF0, 8'h10, pkt_ev(1, 0, ACC ? 977 : 737, ACC ? 233 : 500));

        // Abort mid byte 1 and let the timeout fire.
        exp_q.push_back(ERR_EV);
        send_byte(8'h08, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0]);
        ps2_data = 1'b1;
        repeat (TO + 50) @(negedge clk);
        send_pkt(8'h08, 8'h00, 8'hFF, pkt_ev(0, 0, ACC ? 977 : 737, ACC ? 0 : 245));

        // X overflow masks the delta.
        send_pkt(8'h48, 8'h50, 8'h00, pkt_ev(0, 0, ACC ? 977 : 737, ACC ? 0 : 245));

        // Large negative X walks down to the lower clamp.
        send_pkt(8'h18, 8'h00, 8'h00, pkt_ev(0, 0, ACC ? 465 : 481, ACC ? 0 : 245));
        send_pkt(8'h18, 8'h00, 8'h00, pkt_ev(0, 0, ACC ? 0 : 225, ACC ? 0 : 245));
        send_pkt(8'h18, 8'h00, 8'h00, pkt_ev(0, 0, 0, ACC ? 0 : 245));

        send_pkt(8'h08, 8'h14, 8'h00, pkt_ev(0, 0, ACC ? 40 : 20, ACC ? 0 : 245));
        send_pkt(8'h08, 8'h0F, 8'h00, pkt_ev(0, 0, ACC ? 55 : 35, ACC ? 0 : 245));

        // Positive X walks up to the upper clamp.
        for (int k = 0; k < 4; k++)
            send_pkt(8'h08, 8'hFF, 8'h00, pkt_ev(0, 0, ACC ? x_up_ac[k] : x_up_na[k], ACC ? 0 : 245));

        repeat (50) @(negedge clk);
        check("pending_expected_events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
